// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// Each requester has a valid/ready channel; the winning word is captured
// into a registered output stage that drives the FIFO write side and
// honours fifo_full as backpressure. BURST lets the current owner keep
// the port for up to BURST consecutive beats while others wait.

module fifo_wr_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int BURST   = 1,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_write_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [ID_W-1:0]          grant_id
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST);

  logic [ID_W-1:0]  owner;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0]  winner;
  logic [WIDTH-1:0] win_data;
  logic             burst_keep;
  logic             load_ok;
  logic             xfer;
  logic             handshake;

  // Cyclic search starting after 'last' and ending at 'last' itself.
  // Walking the order backwards and overwriting on every valid hit leaves
  // the highest-priority valid requester as the final pick.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(last) + k) % NUM_REQ;
      pick = valid[ID_W'(idx)] ? ID_W'(idx) : pick;
    end
    return pick;
  endfunction

  // Stage status and winner selection; the owner keeps the port while its
  // burst allowance lasts and it is still offering data.
  always_comb begin
    load_ok    = ~fifo_write_en | ~fifo_full;
    xfer       = fifo_write_en & ~fifo_full;
    burst_keep = (cnt < CNT_MAX) & req_valid[owner];
    winner     = burst_keep ? owner : rr_pick(req_valid, owner);
  end

  // One-hot ready toward the winner and the winner's data word.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    win_data  = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = load_ok & req_valid[k] & (winner == ID_W'(k));
      win_data     = (winner == ID_W'(k)) ? req_data[k*WIDTH +: WIDTH] : win_data;
    end
    handshake = |req_ready;
  end

  // Output stage: load on handshake, empty on a write with nothing new,
  // otherwise hold (including while the FIFO is full).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_write_en <= 1'b0;
      fifo_data_in  <= {WIDTH{1'b0}};
      grant_id      <= {ID_W{1'b0}};
    end else if (handshake) begin
      fifo_write_en <= 1'b1;
      fifo_data_in  <= win_data;
      grant_id      <= winner;
    end else if (xfer) begin
      fifo_write_en <= 1'b0;
    end
  end

  // Arbitration state: last owner and beats taken in its current burst.
  // Reset makes the last requester the owner with an exhausted burst so
  // requester 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= ID_W'(NUM_REQ - 1);
      cnt   <= CNT_MAX;
    end else if (handshake) begin
      cnt   <= ((winner == owner) && (cnt < CNT_MAX)) ? cnt + CNT_W'(1) : CNT_W'(1);
      owner <= winner;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one instance with BURST=1 and one
// with BURST=2 share the same stimulus; each row lists expected outputs
// for both.

module tb_fifo_wr_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic              fifo_full;

  logic [NREQ-1:0]   ready1, ready2;
  logic              we1, we2;
  logic [WIDTH-1:0]  data1, data2;
  logic [1:0]        gid1, gid2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready1), .fifo_full(fifo_full), .fifo_write_en(we1),
    .fifo_data_in(data1), .grant_id(gid1)
  );

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .BURST(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready2), .fifo_full(fifo_full), .fifo_write_en(we2),
    .fifo_data_in(data2), .grant_id(gid2)
  );

  typedef struct packed {
    logic [3:0]  valid;
    logic        full;
    logic        alt;   // all requesters offer 16'h1234 instead of 0A00+i
    logic [3:0]  r1;
    logic        we1;
    logic [1:0]  g1;
    logic [15:0] d1;
    logic [3:0]  r2;
    logic        we2;
    logic [1:0]  g2;
    logic [15:0] d2;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic alt);
    for (int i = 0; i < NREQ; i++)
      req_data[i*WIDTH +: WIDTH] = alt ? 16'h1234 : (16'h0A00 + 16'(i));
  endtask

  task automatic chk_both(input string tag, input logic [3:0] r1, input logic w1,
                          input logic [1:0] g1, input logic [15:0] d1,
                          input logic [3:0] r2, input logic w2,
                          input logic [1:0] g2, input logic [15:0] d2);
    chk({tag, " ready1"}, 32'(ready1), 32'(r1));
    chk({tag, " we1"},    32'(we1),    32'(w1));
    chk({tag, " gid1"},   32'(gid1),   32'(g1));
    chk({tag, " data1"},  32'(data1),  32'(d1));
    chk({tag, " ready2"}, 32'(ready2), 32'(r2));
    chk({tag, " we2"},    32'(we2),    32'(w2));
    chk({tag, " gid2"},   32'(gid2),   32'(g2));
    chk({tag, " data2"},  32'(data2),  32'(d2));
  endtask

  initial begin
    // Round robin / burst with all valid (dut1 BURST=1, dut2 BURST=2)
    tbl[0]  = '{4'hF,1'b0,1'b0, 4'h1,1'b0,2'd0,16'h0000, 4'h1,1'b0,2'd0,16'h0000};
    tbl[1]  = '{4'hF,1'b0,1'b0, 4'h2,1'b1,2'd0,16'h0A00, 4'h1,1'b1,2'd0,16'h0A00};
    tbl[2]  = '{4'hF,1'b0,1'b0, 4'h4,1'b1,2'd1,16'h0A01, 4'h2,1'b1,2'd0,16'h0A00};
    tbl[3]  = '{4'hF,1'b0,1'b0, 4'h8,1'b1,2'd2,16'h0A02, 4'h2,1'b1,2'd1,16'h0A01};
    tbl[4]  = '{4'hF,1'b0,1'b0, 4'h1,1'b1,2'd3,16'h0A03, 4'h4,1'b1,2'd1,16'h0A01};
    tbl[5]  = '{4'hF,1'b0,1'b0, 4'h2,1'b1,2'd0,16'h0A00, 4'h4,1'b1,2'd2,16'h0A02};
    tbl[6]  = '{4'hF,1'b0,1'b0, 4'h4,1'b1,2'd1,16'h0A01, 4'h8,1'b1,2'd2,16'h0A02};
    tbl[7]  = '{4'hF,1'b0,1'b0, 4'h8,1'b1,2'd2,16'h0A02, 4'h8,1'b1,2'd3,16'h0A03};
    tbl[8]  = '{4'hF,1'b0,1'b0, 4'h1,1'b1,2'd3,16'h0A03, 4'h1,1'b1,2'd3,16'h0A03};
    tbl[9]  = '{4'hF,1'b0,1'b0, 4'h2,1'b1,2'd0,16'h0A00, 4'h1,1'b1,2'd0,16'h0A00};
    // Lone requester 2: wins every cycle, no stall
    tbl[10] = '{4'h4,1'b0,1'b0, 4'h4,1'b1,2'd1,16'h0A01, 4'h4,1'b1,2'd0,16'h0A00};
    tbl[11] = '{4'h4,1'b0,1'b0, 4'h4,1'b1,2'd2,16'h0A02, 4'h4,1'b1,2'd2,16'h0A02};
    tbl[12] = '{4'h4,1'b0,1'b0, 4'h4,1'b1,2'd2,16'h0A02, 4'h4,1'b1,2'd2,16'h0A02};
    // Drop-out: requester 1 absent for one cycle, then back
    tbl[13] = '{4'h1,1'b0,1'b0, 4'h1,1'b1,2'd2,16'h0A02, 4'h1,1'b1,2'd2,16'h0A02};
    tbl[14] = '{4'hD,1'b0,1'b0, 4'h4,1'b1,2'd0,16'h0A00, 4'h1,1'b1,2'd0,16'h0A00};
    tbl[15] = '{4'hF,1'b0,1'b0, 4'h8,1'b1,2'd2,16'h0A02, 4'h2,1'b1,2'd0,16'h0A00};
    tbl[16] = '{4'hF,1'b0,1'b0, 4'h1,1'b1,2'd3,16'h0A03, 4'h2,1'b1,2'd1,16'h0A01};
    tbl[17] = '{4'hF,1'b0,1'b0, 4'h2,1'b1,2'd0,16'h0A00, 4'h4,1'b1,2'd1,16'h0A01};
    // Backpressure: load 1234, hold 3 full cycles, release with no bubble
    tbl[18] = '{4'hF,1'b0,1'b1, 4'h4,1'b1,2'd1,16'h0A01, 4'h4,1'b1,2'd2,16'h0A02};
    tbl[19] = '{4'hF,1'b1,1'b0, 4'h0,1'b1,2'd2,16'h1234, 4'h0,1'b1,2'd2,16'h1234};
    tbl[20] = '{4'hF,1'b1,1'b0, 4'h0,1'b1,2'd2,16'h1234, 4'h0,1'b1,2'd2,16'h1234};
    tbl[21] = '{4'hF,1'b1,1'b0, 4'h0,1'b1,2'd2,16'h1234, 4'h0,1'b1,2'd2,16'h1234};
    tbl[22] = '{4'hF,1'b0,1'b0, 4'h8,1'b1,2'd2,16'h1234, 4'h8,1'b1,2'd2,16'h1234};
    // Drain with no requesters: write_en drops, data/grant hold
    tbl[23] = '{4'h0,1'b0,1'b0, 4'h0,1'b1,2'd3,16'h0A03, 4'h0,1'b1,2'd3,16'h0A03};
    tbl[24] = '{4'h0,1'b0,1'b0, 4'h0,1'b0,2'd3,16'h0A03, 4'h0,1'b0,2'd3,16'h0A03};

    // Reset with nothing valid
    reset     = 1'b1;
    req_valid = 4'h0;
    fifo_full = 1'b0;
    set_data(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_both("reset", 4'h0, 1'b0, 2'd0, 16'h0000, 4'h0, 1'b0, 2'd0, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid;
      fifo_full = tbl[i].full;
      set_data(tbl[i].alt);
      #1;
      chk_both($sformatf("row%0d", i), tbl[i].r1, tbl[i].we1, tbl[i].g1, tbl[i].d1,
               tbl[i].r2, tbl[i].we2, tbl[i].g2, tbl[i].d2);
    end

    // Reset mid-operation while the stage is stalled on a full FIFO
    @(negedge clk);
    req_valid = 4'hF;
    fifo_full = 1'b0;
    set_data(1'b0);
    @(negedge clk);
    fifo_full = 1'b1;
    #1;
    chk("midrst pre we1", 32'(we1), 32'd1);
    chk("midrst pre we2", 32'(we2), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_both("midrst async", 4'h1, 1'b0, 2'd0, 16'h0000, 4'h1, 1'b0, 2'd0, 16'h0000);
    @(negedge clk);
    reset     = 1'b0;
    fifo_full = 1'b0;
    #1;
    chk("post rst ready1", 32'(ready1), 32'h1);
    chk("post rst ready2", 32'(ready2), 32'h1);
    @(posedge clk);
    #1;
    chk_both("post rst grant", 4'h2, 1'b1, 2'd0, 16'h0A00, 4'h1, 1'b1, 2'd0, 16'h0A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port between `NUM_REQ` producers, with an optional per-requester burst allowance. Each producer has its own valid/ready channel. The arbiter picks one winner per cycle and captures its word into a registered output stage, which drives the FIFO's `write_en`/`data_in`. It honours the FIFO's `full` flag as backpressure. It sits directly in front of `fifo` and is the only agent that drives its write side.

## Interface

- `WIDTH`, default 16: data word width; must equal the FIFO's `WIDTH`.
- `NUM_REQ`, default 4: number of requesters, ≥2. `ID_W = $clog2(NUM_REQ)`.
- `BURST`, default 1: maximum consecutive accepted beats one requester may take while others wait, ≥1. `BURST = 1` gives pure round-robin.

Ports:

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input `NUM_REQ`: bit i set means requester i offers a word.
- `req_data` input `NUM_REQ*WIDTH`: requester i's word in bits `[i*WIDTH +: WIDTH]`.
- `req_ready` output `NUM_REQ`: one-hot or zero; bit i marks a handshake for requester i this cycle.
- `fifo_full` input 1: the FIFO's `full`.
- `fifo_write_en` output 1: drives the FIFO's `write_en`.
- `fifo_data_in` output `WIDTH`: drives the FIFO's `data_in`.
- `grant_id` output `ID_W`: index of the requester whose word is currently held in the output stage.

## Operation

- State:
  - Output stage: `fifo_write_en`, `fifo_data_in`, `grant_id`.
  - `owner` (`ID_W` bits): last requester granted.
  - `cnt`: beats accepted in the current burst, range 0..`BURST`.
- Stage rules:
  - `xfer = fifo_write_en & ~fifo_full`: the FIFO takes the held word this edge.
  - `load_ok = ~fifo_write_en | ~fifo_full`: the stage is empty or draining this edge.
- Winner selection (combinational):
  - If `cnt < BURST` and `req_valid[owner]`, the winner is `owner`.
  - Otherwise, the winner is the first valid requester in the cyclic order `owner+1, owner+2, …, owner`; the owner is checked last.
- `req_ready[winner] = load_ok & req_valid[winner]`. All other `req_ready` bits are 0, and all bits are 0 when no requester is valid.
- Handshake (`req_valid[i] & req_ready[i]`), registered at the edge:
  - `fifo_write_en <= 1`, `fifo_data_in <= req_data[winner]`, `grant_id <= winner`.
  - `cnt <= (winner == owner && cnt < BURST) ? cnt+1 : 1`, then `owner <= winner`.
- `xfer` with no handshake: `fifo_write_en <= 0`. `fifo_data_in` and `grant_id` hold their last values.
- `fifo_write_en=1` with `fifo_full=1`: the stage holds. `fifo_write_en` stays 1 and the data stays stable until the FIFO accepts the word.
- Simultaneous `xfer` and handshake: the new word replaces the old one. No bubble, full throughput.
- A lone valid requester whose burst is exhausted still wins, because it is last in the search order. Its burst restarts with `cnt = 1`.
- `req_valid` deasserting without a handshake is legal. That requester simply drops out of arbitration.

## Timing

- Reset values:
  - `fifo_write_en = 0`, `fifo_data_in = 0`, `grant_id = 0`.
  - `owner = NUM_REQ-1` and `cnt = BURST`, so requester 0 has first priority.
  - `req_ready = 0`: it is a function of `fifo_write_en = 0` and `req_valid`, so no bit asserts while no requester is valid.
- Reset is asynchronous. An in-flight word in the output stage is discarded, even if `fifo_full` is high at that moment.
- Latency: a word handshaken at edge N is presented to the FIFO (`fifo_write_en=1`) in the cycle after edge N and written at edge N+1 if `fifo_full=0`.
- Throughput: one word per cycle while `fifo_full=0` and any requester is valid.
- `req_ready` is combinational from `req_valid`, `fifo_full` and registered state. There is no combinational path from `req_data` to any output.
- Fairness: with all requesters valid continuously, each gets exactly `BURST` beats per round, in index order.

## Test plan

- Reset check: assert `reset` with all `req_valid=0` → `fifo_write_en=0`, `fifo_data_in=0`, `grant_id=0`, `req_ready=0`.
- Round-robin, `BURST=1`, `NUM_REQ=4`, all valid, requester i offering `16'h0A00+i`, `fifo_full=0` → `grant_id` sequence 0,1,2,3,0,… and `fifo_data_in` 0A00,0A01,0A02,0A03. `fifo_write_en` is high continuously from the second cycle on.
- Burst, `BURST=2`, all valid → grant sequence 0,0,1,1,2,2,3,3,0. With only requester 2 valid → grant 2 every cycle and no stall.
- Backpressure: while holding word `16'h1234`, drive `fifo_full=1` for 3 cycles → `fifo_write_en=1` and `fifo_data_in=16'h1234` stable, `req_ready=0`. Release `fifo_full` → 1234 is written and the next winner loads at the same edge with no idle cycle.
- Drop-out: requester 1 deasserts valid while requester 0 holds the burst (`BURST=1`) → the next grant goes to 2 and 1 is skipped. Requester 1 reasserting is granted in the following round.
- Reset mid-operation: assert `reset` with `fifo_write_en=1` and `fifo_full=1` → `fifo_write_en` goes to 0 without a clock edge. After release with all requesters valid, the first grant is 0.
